// File: rtl/div_monitor.sv
// Divided-clock monitor: measures high/low phase lengths of din, reports each
// complete period with a one-cycle strobe, tracks lock and flags sticky errors.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for a rising edge; any partial phase is discarded
// S_HIGH | din high, hi_cnt counting the high phase
// S_LOW  | din low, lo_cnt counting; next rise closes and reports the period
module div_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             clear,
    output logic             valid,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period,
    output logic             locked,
    output logic             err_unlock,
    output logic             err_ovf
);

    localparam int                 MATCH_W   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t             state;
    state_t             state_d;
    logic               din_q;
    logic               rise;
    logic               fall;
    logic [CNT_W-1:0]   hi_cnt;
    logic [CNT_W-1:0]   hi_cnt_d;
    logic [CNT_W-1:0]   lo_cnt;
    logic [CNT_W-1:0]   lo_cnt_d;
    logic               report;
    logic               ovf;
    logic               prev_vld;
    logic               same_len;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_nx;

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        hi_cnt_d = hi_cnt;
        lo_cnt_d = lo_cnt;
        report   = 1'b0;
        ovf      = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state_d  = S_HIGH;
                        hi_cnt_d = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        state_d  = S_LOW;
                        lo_cnt_d = CNT_ONE;
                    end else if (hi_cnt == CNT_MAX) begin
                        ovf     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        hi_cnt_d = hi_cnt + CNT_ONE;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        report   = 1'b1;
                        state_d  = S_HIGH;
                        hi_cnt_d = CNT_ONE;
                    end else if (lo_cnt == CNT_MAX) begin
                        ovf     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        lo_cnt_d = lo_cnt + CNT_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The reported lengths double as the previous-period reference; prev_vld
    // says whether they are a valid predecessor (not after reset/clear/overflow).
    assign same_len = prev_vld && (hi_cnt == high_len) && (lo_cnt == low_len);

    always_comb begin
        match_nx = '0;
        if (same_len) begin
            match_nx = (match_cnt == MATCH_TGT) ? match_cnt : match_cnt + MATCH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q      <= 1'b1;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            valid      <= 1'b0;
            high_len   <= '0;
            low_len    <= '0;
            period     <= '0;
            locked     <= 1'b0;
            err_unlock <= 1'b0;
            err_ovf    <= 1'b0;
            prev_vld   <= 1'b0;
            match_cnt  <= '0;
        end else begin
            din_q  <= din;
            hi_cnt <= hi_cnt_d;
            lo_cnt <= lo_cnt_d;
            valid  <= 1'b0;
            if (clear) begin
                locked     <= 1'b0;
                err_unlock <= 1'b0;
                err_ovf    <= 1'b0;
                prev_vld   <= 1'b0;
                match_cnt  <= '0;
            end else if (ovf) begin
                locked    <= 1'b0;
                err_ovf   <= 1'b1;
                prev_vld  <= 1'b0;
                match_cnt <= '0;
            end else if (report) begin
                valid     <= 1'b1;
                high_len  <= hi_cnt;
                low_len   <= lo_cnt;
                period    <= {1'b0, hi_cnt} + {1'b0, lo_cnt};
                prev_vld  <= 1'b1;
                match_cnt <= match_nx;
                locked    <= (match_nx == MATCH_TGT);
                if (prev_vld && !same_len && locked) begin
                    err_unlock <= 1'b1;
                end
            end
        end
    end

endmodule
